ring_rr_arbiter: RTL and testbench
==================================

// Module: ring_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one resource among N requesters using a rotating
//  one-hot priority token (ring counter). Grants are registered, held while the owner
//  keeps requesting, and force-released after MAX_HOLD cycles. It sequences access to
//  the ring-counter-driven datapath; the token output mirrors the ring state for debug.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  ID_W      2   width of gnt_id; must satisfy 2**ID_W >= N
//  MAX_HOLD  4   max consecutive cycles gnt stays asserted for one owner (>=1)
// PORTS
//  c          input   1       clock, rising edge
//  rst        input   1       reset, asynchronous, active-high
//  req        input   N       request vector, one bit per requester
//  gnt        output  N       one-hot grant (all-zero when nobody owns the resource)
//  gnt_valid  output  1       1 when gnt != 0
//  gnt_id     output  ID_W    binary index of current owner (0 when gnt_valid=0)
//  token      output  N       one-hot priority ring; bit k = requester k searched first
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, gnt=0, gnt_valid=0, gnt_id=0,
//   token={{N-1{1'b0}},1'b1}, hold_cnt=0. Overrides any cycle in progress.
//  All outputs registered; no combinational path req->gnt.
//  Arbitration: pick first set req bit at token position, searching upward, wrapping N-1->0.
//  States:
//   IDLE:    if |req, at edge -> GRANT, gnt=onehot(winner), hold_cnt=0; else stay.
//            Latency: req sampled high at edge E -> gnt high after E.
//   GRANT:   at each edge: if req[owner]=0 -> RELEASE;
//            else if hold_cnt==MAX_HOLD-1 -> RELEASE (timeout); else hold_cnt++.
//            gnt asserted for at most MAX_HOLD consecutive cycles.
//            Non-owner req changes ignored while in GRANT.
//   RELEASE: entered with gnt=0, gnt_valid=0, gnt_id=0,
//            token=onehot((owner+1) mod N). Lasts exactly 1 cycle (one dead cycle).
//            At next edge arbitrate with updated token: |req -> GRANT, else IDLE.
//  Boundaries:
//   owner drop + other req rise same edge: RELEASE first, other granted next edge.
//   owner re-requests after timeout: lowest priority; re-granted only if no other req.
//   token wrap: owner N-1 -> token bit 0.
//   token stays unchanged in IDLE; it moves only on RELEASE entry.
//   req bits >= N do not exist; gnt_id never exceeds N-1.
// TESTING  (N=4, ID_W=2, MAX_HOLD=4, c period 20ns)
//  1 rst=1 for 50ns, req=0 -> gnt=0000, gnt_valid=0, gnt_id=0, token=0001.
//    Then rst=0 with req=0 -> outputs unchanged for 5 cycles.
//  2 req=0100 for 2 cycles, then 0000 -> gnt=0100, gnt_id=2 from 1 cycle after req for
//    2 cycles; gnt=0000 one cycle after drop; token=1000; then IDLE.
//  3 req=1111 held continuously -> owners 0,1,2,3,0 in order. Each holds gnt 4 cycles,
//    followed by 1 dead cycle. Token steps 0010,0100,1000,0001.
//  4 token=1000, req=0011 -> gnt=0001, gnt_id=0 (wrap).
//    After release token=0010 -> next grant 0010.
//  5 owner 1 granted; owner drops req[1] and req[3] rises same edge
//    -> 1 dead cycle, then gnt=1000.
//  6 rst pulsed high mid-GRANT, between clock edges -> gnt=0000 and token=0001
//    immediately, no clock edge needed. Arbitration resumes from IDLE after release.

Source files
------------

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter driven by a rotating one-hot priority token.
// Grants are registered, held while the owner keeps requesting, and force-released after MAX_HOLD cycles.
module ring_rr_arbiter #(
   parameter int N        = 4,
   parameter int ID_W     = 2,
   parameter int MAX_HOLD = 4
) (
   input  logic            c,
   input  logic            rst,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic            gnt_valid,
   output logic [ID_W-1:0] gnt_id,
   output logic [N-1:0]    token
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [N-1:0]  ONE  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [HW-1:0] LAST = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      RELEASE
   } state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   hold_cnt, hold_d;
   logic [N-1:0]    gnt_d, token_d;
   logic [ID_W-1:0] gnt_id_d;
   logic [ID_W-1:0] tok_id;
   logic [ID_W-1:0] win_id;
   logic [ID_W-1:0] cand;
   logic            win_found;
   int              pos;

   // Binary position of the token; the search for a winner starts here.
   always_comb begin
      tok_id = '0;
      for (int k = 0; k < N; k++) begin
         if (token[k]) tok_id = ID_W'(k);
      end
   end

   // First requester at or above the token position, wrapping from N-1 back to 0.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      pos       = 0;
      cand      = '0;
      for (int i = 0; i < N; i++) begin
         pos = int'(tok_id) + i;
         if (pos >= N) pos = pos - N;
         cand = ID_W'(pos);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   // Next-state and next-output logic; the token only moves on entry to RELEASE.
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt;
      gnt_id_d = gnt_id;
      token_d  = token;
      hold_d   = hold_cnt;
      case (state_q)
         IDLE, RELEASE: begin
            if (win_found) begin
               state_d  = GRANT;
               gnt_d    = ONE << win_id;
               gnt_id_d = win_id;
               hold_d   = '0;
            end else begin
               state_d  = IDLE;
               gnt_d    = '0;
               gnt_id_d = '0;
            end
         end
         GRANT: begin
            if (!(|(req & gnt)) || (hold_cnt == LAST)) begin
               state_d  = RELEASE;
               gnt_d    = '0;
               gnt_id_d = '0;
               token_d  = {gnt[N-2:0], gnt[N-1]};
               hold_d   = '0;
            end else begin
               hold_d = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_d  = IDLE;
            gnt_d    = '0;
            gnt_id_d = '0;
            hold_d   = '0;
         end
      endcase
   end

   // All outputs come straight from flops, so req never reaches gnt combinationally.
   always_ff @(posedge c or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt       <= '0;
         gnt_valid <= 1'b0;
         gnt_id    <= '0;
         token     <= ONE;
         hold_cnt  <= '0;
      end else begin
         state_q   <= state_d;
         gnt       <= gnt_d;
         gnt_valid <= |gnt_d;
         gnt_id    <= gnt_id_d;
         token     <= token_d;
         hold_cnt  <= hold_d;
      end
   end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N=4, MAX_HOLD=4, 20ns clock).
// Expected grant/token sequences are written out by hand below.
module tb_ring_rr_arbiter;

   logic       c;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       gnt_valid;
   logic [1:0] gnt_id;
   logic [3:0] token;

   int vecCount;
   int missCount;

   logic [3:0] expGnt   [5];
   logic [1:0] expId    [5];
   logic [3:0] expToken [5];

   ring_rr_arbiter #(.N(4), .ID_W(2), .MAX_HOLD(4)) dut (
      .c         (c),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id),
      .token     (token)
   );

   initial c = 1'b0;
   always #10 c = ~c;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic [3:0] g, input logic [1:0] id, input logic [3:0] t);
      checkOutput({tag, ".gnt"},   32'(gnt),       32'(g));
      checkOutput({tag, ".valid"}, 32'(gnt_valid), 32'(g != 4'b0000));
      checkOutput({tag, ".id"},    32'(gnt_id),    32'(id));
      checkOutput({tag, ".token"}, 32'(token),     32'(t));
   endtask

   // Drive req, then let one rising edge pass and settle 1ns after it.
   task automatic applyStimulus(input logic [3:0] r);
      req = r;
      @(posedge c);
      #1;
   endtask

   // Reset pulse placed mid-cycle so it never coincides with a clock edge.
   task automatic pulseReset();
      @(posedge c);
      #5;
      req = 4'b0000;
      rst = 1'b1;
      #2;
      checkAll("rst_pulse", 4'b0000, 2'd0, 4'b0001);
      rst = 1'b0;
   endtask

   initial begin
      vecCount  = 0;
      missCount = 0;
      expGnt   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      expId    = '{2'd0,    2'd1,    2'd2,    2'd3,    2'd0};
      expToken = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

      // Power-on reset with no requests, then idle cycles.
      rst = 1'b1;
      req = 4'b0000;
      #50;
      checkAll("reset", 4'b0000, 2'd0, 4'b0001);
      @(negedge c);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b0000);
         checkAll($sformatf("idle%0d", i), 4'b0000, 2'd0, 4'b0001);
      end

      // Single requester 2: grant is registered, held 2 cycles, then one dead cycle.
      req = 4'b0100;
      #1;
      checkOutput("no_comb_path", 32'(gnt), 32'(4'b0000));
      applyStimulus(4'b0100);
      checkAll("r2_g0", 4'b0100, 2'd2, 4'b0001);
      applyStimulus(4'b0100);
      checkAll("r2_g1", 4'b0100, 2'd2, 4'b0001);
      applyStimulus(4'b0000);
      checkAll("r2_rel", 4'b0000, 2'd0, 4'b1000);
      applyStimulus(4'b0000);
      checkAll("r2_idle", 4'b0000, 2'd0, 4'b1000);

      // Token at 3, requests 0 and 1: search wraps to 0; after timeout 1 wins.
      applyStimulus(4'b0011);
      checkAll("wrap_g0", 4'b0001, 2'd0, 4'b1000);
      for (int i = 1; i < 4; i++) begin
         applyStimulus(4'b0011);
         checkAll($sformatf("wrap_hold%0d", i), 4'b0001, 2'd0, 4'b1000);
      end
      applyStimulus(4'b0011);
      checkAll("wrap_rel", 4'b0000, 2'd0, 4'b0010);
      applyStimulus(4'b0011);
      checkAll("wrap_next", 4'b0010, 2'd1, 4'b0010);
      applyStimulus(4'b0000);
      checkAll("wrap_drop", 4'b0000, 2'd0, 4'b0100);

      // All four requesting: each owner holds 4 cycles, then a dead cycle.
      pulseReset();
      for (int o = 0; o < 5; o++) begin
         for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1111);
            checkAll($sformatf("rr_o%0d_c%0d", o, k), expGnt[o], expId[o], expToken[(o + 4) % 5 == 4 && o == 0 ? 3 : (o + 4) % 5]);
         end
         applyStimulus(4'b1111);
         checkAll($sformatf("rr_rel%0d", o), 4'b0000, 2'd0, expToken[o]);
      end

      // Owner 1 drops while requester 3 rises on the same edge.
      pulseReset();
      applyStimulus(4'b0010);
      checkAll("sw_g1", 4'b0010, 2'd1, 4'b0001);
      applyStimulus(4'b1000);
      checkAll("sw_dead", 4'b0000, 2'd0, 4'b0100);
      applyStimulus(4'b1000);
      checkAll("sw_g3", 4'b1000, 2'd3, 4'b0100);

      // Asynchronous reset mid-grant, then arbitration restarts from token 0.
      #4;
      rst = 1'b1;
      #1;
      checkAll("async_rst", 4'b0000, 2'd0, 4'b0001);
      #2;
      rst = 1'b0;
      applyStimulus(4'b1000);
      checkAll("post_rst", 4'b1000, 2'd3, 4'b0001);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL timeout: got running, expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
